// File: rtl/hd_transfer_ctrl.sv
// -----------------------------------------------------------------------------
// hd_transfer_ctrl
//   Moves a block of 32-bit words between a track/sector addressed hard drive
//   and a 1024-word memory. direction=0 loads (drive -> memory, one word per
//   cycle). direction=1 stores (memory -> drive, FETCH + STORE per word).
//
// Ports
//   clock, reset                  single clock, asynchronous active-high reset
//   start, direction              transfer request (sampled in IDLE), 0=load 1=store
//   start_track/_sector/_mem_addr first drive and memory addresses
//   word_count                    number of words to move, 0..1024
//   busy, done, error             status: busy outside IDLE, one-cycle done,
//                                 error held until the next accepted start
//   hd_track, hd_sector           drive address
//   hd_data_write, hd_flag_write  drive write data and strobe
//   hd_data_read                  drive read data, combinational from the address
//   mem_addr, mem_data_write      memory address and write data
//   mem_write                     memory write strobe
//   mem_data_read                 memory read data, valid one cycle after mem_addr
// -----------------------------------------------------------------------------
module hd_transfer_ctrl #(
   parameter int unsigned SECTORS_PER_TRACK = 64,
   parameter int unsigned TRACKS            = 128
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        direction,
   input  logic [6:0]  start_track,
   input  logic [13:0] start_sector,
   input  logic [9:0]  start_mem_addr,
   input  logic [10:0] word_count,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [6:0]  hd_track,
   output logic [13:0] hd_sector,
   output logic [31:0] hd_data_write,
   output logic        hd_flag_write,
   input  logic [31:0] hd_data_read,
   output logic [9:0]  mem_addr,
   output logic [31:0] mem_data_write,
   output logic        mem_write,
   input  logic [31:0] mem_data_read
);

   localparam logic [13:0] SECTOR_LAST = 14'(SECTORS_PER_TRACK - 1);
   localparam logic [6:0]  TRACK_LAST  = 7'(TRACKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_LOAD,
      S_FETCH,
      S_STORE,
      S_FINISH
   } state_t;

   state_t      state_q;

   // Request captured in IDLE, validated in CHECK.
   logic [6:0]  lat_track_q;
   logic [13:0] lat_sector_q;
   logic        dir_q;
   logic [10:0] cnt_q;

   // Registered outputs.
   logic        busy_q;
   logic        done_q;
   logic        error_q;
   logic        mem_write_q;
   logic        hd_flag_write_q;
   logic [6:0]  hd_track_q;
   logic [13:0] hd_sector_q;
   logic [9:0]  mem_addr_q;
   logic [31:0] hd_data_write_q;

   // Next-address and decision terms.
   logic        start_bad_d;
   logic        last_word_d;
   logic        sector_wrap_d;
   logic        track_ovf_d;
   logic [13:0] sector_next_d;
   logic [6:0]  track_next_d;
   logic [9:0]  mem_addr_next_d;

   // NOTE: every variable written in always_comb is assigned on every path,
   // so no latch can be inferred.
   always_comb begin
      start_bad_d     = (32'(lat_sector_q) >= SECTORS_PER_TRACK) ||
                        (32'(lat_track_q)  >= TRACKS);
      last_word_d     = (cnt_q == 11'd1);
      sector_wrap_d   = (hd_sector_q == SECTOR_LAST);
      track_ovf_d     = sector_wrap_d && (hd_track_q == TRACK_LAST);
      sector_next_d   = sector_wrap_d ? 14'd0 : hd_sector_q + 14'd1;
      track_next_d    = sector_wrap_d ? hd_track_q + 7'd1 : hd_track_q;
      mem_addr_next_d = mem_addr_q + 10'd1;   // wraps modulo 1024
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // in this block samples the values that were present before the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         lat_track_q     <= '0;
         lat_sector_q    <= '0;
         dir_q           <= 1'b0;
         cnt_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
         mem_write_q     <= 1'b0;
         hd_flag_write_q <= 1'b0;
         hd_track_q      <= '0;
         hd_sector_q     <= '0;
         mem_addr_q      <= '0;
         hd_data_write_q <= '0;
      end else begin
         // Strobes are single-cycle unless the next state re-asserts them.
         done_q          <= 1'b0;
         mem_write_q     <= 1'b0;
         hd_flag_write_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  lat_track_q  <= start_track;
                  lat_sector_q <= start_sector;
                  dir_q        <= direction;
                  cnt_q        <= word_count;
                  // Presenting the first memory address already in CHECK lets
                  // the read data for the first stored word arrive by FETCH.
                  mem_addr_q   <= start_mem_addr;
                  error_q      <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (start_bad_d) begin
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else if (cnt_q == 11'd0) begin
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else begin
                  hd_track_q  <= lat_track_q;
                  hd_sector_q <= lat_sector_q;
                  if (!dir_q) begin
                     mem_write_q <= 1'b1;
                     state_q     <= S_LOAD;
                  end else begin
                     state_q     <= S_FETCH;
                  end
               end
            end

            // One word per cycle: the memory write strobe is high throughout
            // LOAD and the data path is hd_data_read straight to memory.
            S_LOAD: begin
               cnt_q <= cnt_q - 11'd1;
               if (last_word_d) begin
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else if (track_ovf_d) begin
                  // Ran off the last track with words still pending.
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else begin
                  hd_sector_q <= sector_next_d;
                  hd_track_q  <= track_next_d;
                  mem_addr_q  <= mem_addr_next_d;
                  mem_write_q <= 1'b1;
               end
            end

            // The word for this iteration is on mem_data_read now; register it
            // so data, strobe and drive address line up during STORE, and move
            // the memory address on so the next word is read during STORE.
            S_FETCH: begin
               hd_data_write_q <= mem_data_read;
               hd_flag_write_q <= 1'b1;
               if (!last_word_d) begin
                  mem_addr_q <= mem_addr_next_d;
               end
               state_q <= S_STORE;
            end

            S_STORE: begin
               cnt_q <= cnt_q - 11'd1;
               if (last_word_d) begin
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else if (track_ovf_d) begin
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else begin
                  hd_sector_q <= sector_next_d;
                  hd_track_q  <= track_next_d;
                  state_q     <= S_FETCH;
               end
            end

            S_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign hd_track       = hd_track_q;
   assign hd_sector      = hd_sector_q;
   assign hd_data_write  = hd_data_write_q;
   assign hd_flag_write  = hd_flag_write_q;
   assign mem_addr       = mem_addr_q;
   assign mem_write      = mem_write_q;
   assign mem_data_write = hd_data_read;

endmodule
